// File: rtl/piso_serializer.sv
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in serial-out transmitter, MSB first, valid/ready load.
//                Optional even-parity trailer cycle when PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             data_out,
    output logic             out_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
`ifdef PARITY_EN
    logic               r_parity;
    logic               w_parity_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_count  <= '0;
`ifdef PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_count  <= w_count_nxt;
`ifdef PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    // Outputs come only from registered state; load_valid affects next state only.
    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_count_nxt  = r_count;
`ifdef PARITY_EN
        w_parity_nxt = r_parity;
`endif
        data_out     = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;
        load_ready   = 1'b0;

        case (r_state)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_state_nxt  = S_SHIFT;
                    w_shreg_nxt  = load_data;
                    w_count_nxt  = '0;
`ifdef PARITY_EN
                    w_parity_nxt = ^load_data;
`endif
                end
            end

            S_SHIFT: begin
                data_out    = r_shreg[WIDTH-1];
                out_valid   = 1'b1;
                w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                w_count_nxt = r_count + 1'b1;
                if (r_count == c_last_count) begin
`ifdef PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    done       = 1'b1;
                    load_ready = 1'b1;
                    w_count_nxt = '0;
                    if (load_valid) begin
                        w_shreg_nxt = load_data;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
`endif
                end
            end

`ifdef PARITY_EN
            S_PARITY: begin
                data_out    = r_parity;
                out_valid   = 1'b1;
                done        = 1'b1;
                load_ready  = 1'b1;
                w_count_nxt = '0;
                if (load_valid) begin
                    w_state_nxt  = S_SHIFT;
                    w_shreg_nxt  = load_data;
                    w_parity_nxt = ^load_data;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
`endif

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
